// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: PC width, reset vector and the
// sequencer state encoding.
package cpu_pkg;

    localparam int PC_WIDTH = 16;

    localparam logic [PC_WIDTH-1:0] DEFAULT_RESET_VECTOR = 16'h0000;

    localparam logic [1:0] ST_BOOT     = 2'd0;
    localparam logic [1:0] ST_FETCH    = 2'd1;
    localparam logic [1:0] ST_REDIRECT = 2'd2;
    localparam logic [1:0] ST_HALTED   = 2'd3;

    typedef enum logic [1:0] {
        BOOT     = ST_BOOT,
        FETCH    = ST_FETCH,
        REDIRECT = ST_REDIRECT,
        HALTED   = ST_HALTED
    } seq_state_t;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: taken branch > jump > sequential advance > hold.
module pc_next_sel
    import cpu_pkg::*;
(
    input  logic [PC_WIDTH-1:0] pc,
    input  logic                advance,
    input  logic                redirect_en,
    input  logic                br_valid,
    input  logic                br_taken,
    input  logic [PC_WIDTH-1:0] br_imm,
    input  logic [PC_WIDTH-1:0] br_pc_plus_two,
    input  logic                jmp_valid,
    input  logic [PC_WIDTH-1:0] jmp_target,
    output logic [PC_WIDTH-1:0] next_pc,
    output logic                redirect
);

    logic                br_redirect;
    logic [PC_WIDTH-1:0] br_target;
    logic [PC_WIDTH-1:0] jmp_addr;

    // Immediate is in halfwords; the shift drops bit 15 and the add wraps.
    assign br_redirect = br_valid & br_taken;
    assign br_target   = br_pc_plus_two + (br_imm << 1);
    assign jmp_addr    = jmp_target & ~PC_WIDTH'(1);
    assign redirect    = redirect_en & (br_redirect | jmp_valid);

    always_comb begin
        next_pc = pc;
        if (redirect) begin
            next_pc = br_redirect ? br_target : jmp_addr;
        end else if (advance) begin
            next_pc = pc + PC_WIDTH'(2);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction-fetch PC sequencer: boot, sequential fetch, branch/jump
// redirect with one-cycle flush, and halt handling.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fetch_ready,
    input  logic                stall,
    input  logic                halt_req,
    input  logic                br_valid,
    input  logic                br_taken,
    input  logic [PC_WIDTH-1:0] br_imm,
    input  logic [PC_WIDTH-1:0] br_pc_plus_two,
    input  logic                jmp_valid,
    input  logic [PC_WIDTH-1:0] jmp_target,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_plus_two,
    output logic                fetch_valid,
    output logic                flush,
    output logic                halted,
    output logic [7:0]          redirect_count
);

    seq_state_t          state_reg;
    seq_state_t          state_next;
    logic [PC_WIDTH-1:0] pc_reg;
    logic [PC_WIDTH-1:0] pc_next;
    logic                flush_reg;
    logic [7:0]          count_reg;
    logic                advance;
    logic                redirect_en;
    logic                redirect;

    // During BOOT and the flush cycle the execute/decode stages hold only
    // squashed work, so their redirect requests are not honoured.
    assign redirect_en = (state_reg == FETCH) || (state_reg == HALTED);
    assign advance     = (state_reg == FETCH) && fetch_ready && !stall;

    pc_next_sel u_pc_next_sel (
        .pc             (pc_reg),
        .advance        (advance),
        .redirect_en    (redirect_en),
        .br_valid       (br_valid),
        .br_taken       (br_taken),
        .br_imm         (br_imm),
        .br_pc_plus_two (br_pc_plus_two),
        .jmp_valid      (jmp_valid),
        .jmp_target     (jmp_target),
        .next_pc        (pc_next),
        .redirect       (redirect)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            BOOT:     state_next = FETCH;
            FETCH: begin
                if (redirect) begin
                    state_next = REDIRECT;
                end else if (halt_req && (fetch_ready || stall)) begin
                    state_next = HALTED;
                end
            end
            REDIRECT: state_next = halt_req ? HALTED : FETCH;
            HALTED: begin
                if (!redirect && !halt_req) begin
                    state_next = FETCH;
                end
            end
            default:  state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= BOOT;
            pc_reg    <= RESET_VECTOR;
            flush_reg <= 1'b0;
            count_reg <= 8'h00;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            flush_reg <= redirect;
            if (redirect && (count_reg != 8'hFF)) begin
                count_reg <= count_reg + 8'h01;
            end
        end
    end

    assign pc             = pc_reg;
    assign pc_plus_two    = pc_reg + PC_WIDTH'(2);
    assign fetch_valid    = (state_reg == FETCH);
    assign flush          = flush_reg;
    assign halted         = (state_reg == HALTED);
    assign redirect_count = count_reg;

endmodule
